// File: rtl/ksa_mp_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ksa_mp_add_ctrl                                                   |
// | Desc   : Multi-precision add/sub, one N-bit Kogge-Stone adder time-shared  |
// |          over W slices, LSB slice first, with valid/ready handshakes.      |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+

module ksa_prefix_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  localparam int c_L = (N > 1) ? $clog2(N) : 0;

  logic [N-1:0] w_g [0:c_L];
  logic [N-1:0] w_p [0:c_L];
  logic         w_unused_p;

  // Carry-in is folded into bit 0's generate, so group generates are carries.
  generate
    for (genvar i = 0; i < N; i++) begin : g_bit
      assign w_p[0][i] = a[i] ^ b[i];
      if (i == 0) begin : g_lsb
        assign w_g[0][i] = (a[i] & b[i]) | ((a[i] ^ b[i]) & ci);
      end else begin : g_oth
        assign w_g[0][i] = a[i] & b[i];
      end
    end

    for (genvar l = 0; l < c_L; l++) begin : g_lvl
      for (genvar i = 0; i < N; i++) begin : g_node
        if (i >= (1 << l)) begin : g_comb
          assign w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][i-(1<<l)]);
          assign w_p[l+1][i] = w_p[l][i] & w_p[l][i-(1<<l)];
        end else begin : g_pass
          assign w_g[l+1][i] = w_g[l][i];
          assign w_p[l+1][i] = w_p[l][i];
        end
      end
    end

    for (genvar i = 0; i < N; i++) begin : g_sum
      if (i == 0) begin : g_s0
        assign s[i] = w_p[0][i] ^ ci;
      end else begin : g_si
        assign s[i] = w_p[0][i] ^ w_g[c_L][i-1];
      end
    end
  endgenerate

  assign co = w_g[c_L][N-1];

  always_comb begin
    w_unused_p = 1'b0;
    for (int l = 0; l <= c_L; l++) w_unused_p = w_unused_p ^ (^w_p[l]);
  end
endmodule

module ksa_mp_add_ctrl #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] op_a,
  input  logic [N*W-1:0] op_b,
  input  logic           op_sub,
  input  logic           cin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] sum,
  output logic           cout,
  output logic           ovf
);
  localparam int c_CW  = (W > 1) ? $clog2(W) : 1;
  localparam int c_MSB = N*W - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic            r_carry;
  logic [N*W-1:0]  r_a;
  logic [N*W-1:0]  r_b;
  logic [N*W-1:0]  r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic [N-1:0]    w_a_s;
  logic [N-1:0]    w_b_s;
  logic [N-1:0]    w_s;
  logic            w_co;
  logic            w_last;

  always_comb begin
    w_a_s = '0;
    w_b_s = '0;
    for (int i = 0; i < W; i++) begin
      if (int'(r_cnt) == i) begin
        w_a_s = r_a[i*N +: N];
        w_b_s = r_b[i*N +: N];
      end
    end
  end

  assign w_last = (int'(r_cnt) == W - 1);

  ksa_prefix_adder #(.N(N)) u_adder (
    .a  (w_a_s),
    .b  (w_b_s),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= op_sub ? ~op_b : op_b;
            r_carry <= op_sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < W; i++) begin
            if (int'(r_cnt) == i) r_sum[i*N +: N] <= w_s;
          end
          r_carry <= w_co;
          if (w_last) begin
            r_cout  <= w_co;
            r_ovf   <= (r_a[c_MSB] == r_b[c_MSB]) && (w_s[N-1] != r_a[c_MSB]);
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_ksa_mp_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ksa_mp_add_ctrl                                                |
// | Desc   : Directed vector bench for ksa_mp_add_ctrl (N=16, W=4).            |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_ksa_mp_add_ctrl;
  localparam int N = 16;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   op_a = '0;
  logic [63:0]   op_b = '0;
  logic          op_sub = 1'b0;
  logic          cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   sum;
  logic          cout;
  logic          ovf;

  int n_applied = 0;
  int n_bad     = 0;

  ksa_mp_add_ctrl #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        ci;
    logic [63:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    op_a     = v.a;
    op_b     = v.b;
    op_sub   = v.sub;
    cin      = v.ci;
    in_valid = 1'b1;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic check_result(input string name, input vec_t v, input int lat);
    chk({name, ".latency"}, 64'(lat), 64'd4);
    chk({name, ".sum"},  sum,        v.s);
    chk({name, ".cout"}, 64'(cout),  64'(v.co));
    chk({name, ".ovf"},  64'(ovf),   64'(v.ov));
  endtask

  task automatic drain;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drain.out_valid", 64'(out_valid), 64'd0);
    chk("drain.in_ready",  64'(in_ready),  64'd1);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat);
    check_result(name, v, lat);
    drain();
  endtask

  initial begin
    int   lat;
    vec_t v;

    //         a                      b                      sub   cin   sum                    cout  ovf
    vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                 1'b0, 1'b0, 64'h0,                 1'b1, 1'b0};
    vecs[1]  = '{64'h5,                   64'h7,                 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1,                 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3]  = '{64'h8000_0000_0000_0000, 64'h1,                 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[4]  = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b1, 64'h0001_0000_0001_0001, 1'b0, 1'b0};
    vecs[5]  = '{64'h1,                   64'h2,                 1'b0, 1'b1, 64'h4,                 1'b0, 1'b0};
    vecs[6]  = '{64'h7,                   64'h5,                 1'b1, 1'b0, 64'h2,                 1'b1, 1'b0};
    vecs[7]  = '{64'h1234,                64'h1234,              1'b1, 1'b0, 64'h0,                 1'b1, 1'b0};
    vecs[8]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0,               1'b1, 1'b1};
    vecs[9]  = '{64'h0,                   64'h1,                 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[10] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1, 64'h0,               1'b1, 1'b0};

    // Reset state, checked before any clock edge.
    #3;
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.sum",       sum,            64'd0);
    chk("rst.cout",      64'(cout),      64'd0);
    chk("rst.ovf",       64'(ovf),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: hold DONE for 3 cycles while a new request is pending.
    @(negedge clk);
    drive(vecs[5]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat);
    check_result("bp.first", vecs[5], lat);
    v = '{64'h5, 64'h7, 1'b0, 1'b0, 64'hC, 1'b0, 1'b0};
    @(negedge clk);
    drive(v);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp.out_valid", 64'(out_valid), 64'd1);
      chk("bp.in_ready",  64'(in_ready),  64'd0);
      chk("bp.sum",       sum,            64'h4);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp.idle.out_valid", 64'(out_valid), 64'd0);
    chk("bp.idle.in_ready",  64'(in_ready),  64'd1);
    chk("bp.idle.sum_kept",  sum,            64'h4);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp.accept.in_ready", 64'(in_ready), 64'd0);
    wait_result(lat);
    check_result("bp.second", v, lat);
    drain();

    // Reset mid-RUN after slice 1: result dropped, nothing emitted afterwards.
    @(negedge clk);
    drive(vecs[5]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.in_ready",  64'(in_ready),  64'd1);
    chk("abort.out_valid", 64'(out_valid), 64'd0);
    chk("abort.sum",       sum,            64'd0);
    chk("abort.cout",      64'(cout),      64'd0);
    chk("abort.ovf",       64'(ovf),       64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    chk("abort.no_output", 64'(lat), 64'd0);

    // Request pending at reset release is taken on the first edge.
    @(negedge clk);
    rst_n = 1'b0;
    drive(vecs[6]);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("rel.accept.in_ready", 64'(in_ready), 64'd0);
    wait_result(lat);
    check_result("rel", vecs[6], lat);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/ksa_mp_add_ctrl.md
KSA_MP_ADD_CTRL -- requirements
Module: ksa_mp_add_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, giving the slice width in bits of the single shared adder.
REQ-002 SHALL have parameter W, default 4, giving the number of slices per operand (operand width N*W, default 64).
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand request valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-007 SHALL have port op_a, input, N*W bits: operand A.
REQ-008 SHALL have port op_b, input, N*W bits: operand B.
REQ-009 SHALL have port op_sub, input, 1 bit: 1 = A-B, 0 = A+B.
REQ-010 SHALL have port cin, input, 1 bit: carry-in for add, ignored for sub.
REQ-011 SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-013 SHALL have port sum, output, N*W bits: result.
REQ-014 SHALL have port cout, output, 1 bit: carry out of MSB (sub: 1 = no borrow).
REQ-015 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 SHALL contain exactly one N-bit Kogge-Stone prefix adder instance, time-shared across all slices; no other adder on the datapath.
REQ-017 SHALL implement states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 SHALL, on a rising edge with state IDLE and in_valid=1, capture op_a, op_b (inverted when op_sub=1), carry register = (op_sub ? 1 : cin), slice counter = 0, go to RUN.
REQ-019 SHALL, in RUN, feed slice i (bits i*N+N-1 : i*N) of captured A, B and the carry register to the adder; on each edge write adder sum into sum slice i, adder carry-out into the carry register, increment counter.
REQ-020 SHALL, on the edge processing slice W-1, go to DONE, load cout from adder carry-out, and load ovf = (A[MSB] == B'[MSB]) and (sum[MSB] != A[MSB]), with B' the (possibly inverted) captured B.
REQ-021 SHALL give latency of exactly W clocks: out_valid rises W edges after the accepting edge.
REQ-022 SHALL hold sum, cout, ovf, out_valid stable in DONE while out_ready=0 (backpressure of any length).
REQ-023 SHALL, on an edge in DONE with out_ready=1, return to IDLE; out_valid deasserts; sum/cout/ovf keep last values.
REQ-024 SHALL ignore in_valid and input operands while in RUN or DONE; no request queued.
REQ-025 SHALL wrap the slice counter only via the state transition; counter width ceil(log2(W)), W=1 supported (RUN lasts one cycle).
REQ-026 SHALL be fully registered on all outputs; in_ready and out_valid decoded from state registers only.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronously, independent of clk), force state IDLE, counter 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0, in_ready 1.
REQ-028 SHALL, on reset asserted in RUN or DONE, abort the operation and drop the result; no output after release until a new request.
REQ-029 SHALL accept a request on the first rising edge after rst_n deasserts if in_valid=1.

Verification (N=16, W=4)
REQ-030 SHALL cover: add A=0xFFFF_FFFF_FFFF_FFFF, B=1, cin=0 -> out_valid 4 edges after accept, sum=0, cout=1, ovf=0.
REQ-031 SHALL cover: sub A=5, B=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
REQ-032 SHALL cover: add A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0; sub A=0x8000_0000_0000_0000, B=1 -> ovf=1.
REQ-033 SHALL cover: out_ready=0 for 3 cycles in DONE with in_valid=1 throughout -> sum/out_valid stable, in_ready=0, second request accepted only on the edge after return to IDLE.
REQ-034 SHALL cover: rst_n pulsed low mid-RUN (after slice 1) -> all outputs 0, in_ready=1 immediately, no out_valid after release.
REQ-035 SHALL cover: add A=0x0000_FFFF_0000_FFFF, B=0x0000_0001_0000_0001, cin=1 -> sum=0x0001_0000_0001_0001, verifying carry propagation across slice boundaries.
